// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and zero-count helper for the segmented beat packer.
package seg_pkg;
  localparam int SEG_BYTES = 8;
  localparam int ZERO_W    = 12;
  localparam int PKT_W     = 4;

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  // Bytes between the eop byte and the end of the beat for an eop word in
  // segment seg. mod==0 means all 8 bytes of the word are valid.
  function automatic logic [ZERO_W-1:0] zero_num(input int unsigned seg, input logic [2:0] mod);
    logic [ZERO_W-1:0] base;
    base = ZERO_W'(seg * SEG_BYTES);
    return (mod == 3'd0) ? base : base + ZERO_W'(SEG_BYTES) - ZERO_W'(mod);
  endfunction
endpackage

// File: rtl/seg_beat_packer_if.sv
// Word-stream input, segmented-beat output and error pulse of the beat packer.
interface seg_beat_packer_if #(parameter int SEG_NUM = 64);
  logic                    in_sop;
  logic                    in_eop;
  logic                    in_dval;
  logic [2:0]              in_mod;
  logic [63:0]             in_dout;
  logic                    in_rdy;
  logic                    out_rdy;
  logic                    out_vld;
  logic [SEG_NUM-1:0]      out_seg_sop;
  logic [SEG_NUM-1:0]      out_seg_eop;
  logic [SEG_NUM-1:0]      out_seg_dval;
  logic [4*SEG_NUM-1:0]    out_seg_packet_num;
  logic [12*SEG_NUM-1:0]   out_seg_zero_num;
  logic [64*SEG_NUM-1:0]   out_seg_dout;
  logic                    err_sop;

  modport master (
    output in_sop, in_eop, in_dval, in_mod, in_dout, out_rdy,
    input  in_rdy, out_vld, out_seg_sop, out_seg_eop, out_seg_dval,
           out_seg_packet_num, out_seg_zero_num, out_seg_dout, err_sop
  );

  modport slave (
    input  in_sop, in_eop, in_dval, in_mod, in_dout, out_rdy,
    output in_rdy, out_vld, out_seg_sop, out_seg_eop, out_seg_dval,
           out_seg_packet_num, out_seg_zero_num, out_seg_dout, err_sop
  );
endinterface

// File: rtl/seg_beat_outreg.sv
// Single-entry output holding register with valid/ready handshake.
module seg_beat_outreg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic         vld,
  output logic [W-1:0] dout
);
  // Load on push (caller guarantees the slot is free or draining); clear vld on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (push) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end
endmodule

// File: rtl/seg_beat_packer.sv
// Packs 64-bit packet words into SEG_NUM-segment beats, MSB segment first,
// with per-segment flags, packet ordinal, zero count and idle-flush of partial beats.
module seg_beat_packer import seg_pkg::*; #(
  parameter int SEG_NUM       = 64,
  parameter int FLUSH_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  seg_beat_packer_if.slave bus
);
  localparam int IW = $clog2(SEG_NUM);
  localparam int CW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam int BW = SEG_NUM * (3 + PKT_W + ZERO_W + 64);

  state_t                           state, state_nxt;
  logic [IW-1:0]                    widx;
  logic [PKT_W-1:0]                 pkt_cnt, pkt_cur;
  logic [CW-1:0]                    idle_cnt;
  logic                             in_pkt, err_q;
  logic                             accept, wr, err, last_seg, flush, out_free, push, out_vld;
  logic [SEG_NUM-1:0]               acc_sop, acc_eop, acc_dval, nxt_sop, nxt_eop, nxt_dval;
  logic [SEG_NUM-1:0][PKT_W-1:0]    acc_pnum, nxt_pnum;
  logic [SEG_NUM-1:0][ZERO_W-1:0]   acc_zero, nxt_zero;
  logic [SEG_NUM-1:0][63:0]         acc_dout, nxt_dout;
  logic [BW-1:0]                    beat_in, beat_out;

  assign bus.in_rdy  = (state != FULL);
  assign accept      = bus.in_dval && bus.in_rdy;
  // A word is packed if it opens a packet or continues one; non-sop words outside a packet are dropped.
  assign wr          = accept && (bus.in_sop || in_pkt);
  // sop inside a packet, or non-sop outside one.
  assign err         = accept && (bus.in_sop == in_pkt);
  assign last_seg    = (widx == '0);
  assign out_free    = !out_vld || bus.out_rdy;
  assign pkt_cur     = (state == IDLE) ? PKT_W'(1) : pkt_cnt;
  assign bus.err_sop = err_q;
  assign bus.out_vld = out_vld;

  if (FLUSH_TIMEOUT > 0) begin : g_flush
    assign flush = (state == FILL) && !accept && !in_pkt && (idle_cnt == CW'(FLUSH_TIMEOUT - 1));
  end else begin : g_noflush
    assign flush = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and push into the output register: a completed or flushed beat
  // goes straight out if the slot is free, otherwise it is parked in FULL.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE, FILL: begin
        if ((wr && last_seg) || flush) begin
          push      = out_free;
          state_nxt = out_free ? IDLE : FULL;
        end else if (wr) begin
          state_nxt = FILL;
        end
      end
      FULL: begin
        if (bus.out_rdy) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat under construction: starts from zero at beat start so no stale
  // segments survive, then the accepted word overwrites its segment.
  always_comb begin
    nxt_sop  = (state == IDLE) ? '0 : acc_sop;
    nxt_eop  = (state == IDLE) ? '0 : acc_eop;
    nxt_dval = (state == IDLE) ? '0 : acc_dval;
    nxt_pnum = (state == IDLE) ? '0 : acc_pnum;
    nxt_zero = (state == IDLE) ? '0 : acc_zero;
    nxt_dout = (state == IDLE) ? '0 : acc_dout;
    if (wr) begin
      nxt_sop[widx]  = bus.in_sop;
      nxt_eop[widx]  = bus.in_eop;
      nxt_dval[widx] = 1'b1;
      nxt_pnum[widx] = pkt_cur;
      nxt_zero[widx] = bus.in_eop ? zero_num(32'(widx), bus.in_mod) : '0;
      nxt_dout[widx] = bus.in_dout;
    end
  end

  // Accumulator, write index, packet tracking, idle timer and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx     <= IW'(SEG_NUM - 1);
      pkt_cnt  <= PKT_W'(1);
      idle_cnt <= '0;
      in_pkt   <= 1'b0;
      err_q    <= 1'b0;
      acc_sop  <= '0;
      acc_eop  <= '0;
      acc_dval <= '0;
      acc_pnum <= '0;
      acc_zero <= '0;
      acc_dout <= '0;
    end else begin
      acc_sop  <= nxt_sop;
      acc_eop  <= nxt_eop;
      acc_dval <= nxt_dval;
      acc_pnum <= nxt_pnum;
      acc_zero <= nxt_zero;
      acc_dout <= nxt_dout;
      err_q    <= err;
      if (wr) begin
        in_pkt  <= !bus.in_eop;
        widx    <= last_seg ? IW'(SEG_NUM - 1) : widx - 1'b1;
        pkt_cnt <= (bus.in_eop && pkt_cur != '1) ? pkt_cur + 1'b1 : pkt_cur;
      end else if (flush) begin
        widx    <= IW'(SEG_NUM - 1);
      end
      if (accept || state != FILL || flush) idle_cnt <= '0;
      else if (!in_pkt && idle_cnt != '1)  idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign beat_in = {nxt_sop, nxt_eop, nxt_dval, nxt_pnum, nxt_zero, nxt_dout};

  seg_beat_outreg #(.W(BW)) u_outreg (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (beat_in),
    .rdy  (bus.out_rdy),
    .vld  (out_vld),
    .dout (beat_out)
  );

  assign {bus.out_seg_sop, bus.out_seg_eop, bus.out_seg_dval, bus.out_seg_packet_num,
          bus.out_seg_zero_num, bus.out_seg_dout} = beat_out;
endmodule

// File: tb/tb_seg_beat_packer.sv
// Directed, table-driven bench for seg_beat_packer (SEG_NUM=64, FLUSH_TIMEOUT=16).
module tb_seg_beat_packer;
  localparam int SN = 64;
  localparam int FT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_beat_packer_if #(.SEG_NUM(SN)) bus();
  seg_beat_packer #(.SEG_NUM(SN), .FLUSH_TIMEOUT(FT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [SN-1:0]    sop, eop, dval;
    logic [4*SN-1:0]  pnum;
    logic [12*SN-1:0] zero;
    logic [64*SN-1:0] dout;
  } beat_t;

  typedef struct {
    int bi; int seg; int sop; int eop; int dval; int pnum; int zero;
    logic [63:0] dout;
  } seg_vec_t;

  beat_t       beats[$];
  beat_t       mon_b;
  logic [63:0] ref_q[$];
  int          n_chk = 0, n_pass = 0, err_cnt = 0;
  seg_vec_t    t1[7], t2[3], t3[5], t4[6], t5[2], t6[4];

  localparam logic [63:0] A0 = 64'hA000_0000_0000_0000;
  localparam logic [63:0] B0 = 64'hB000_0000_0000_0000;
  localparam logic [63:0] C0 = 64'hC000_0000_0000_0000;
  localparam logic [63:0] D0 = 64'hD000_0000_0000_0000;
  localparam logic [63:0] E0 = 64'hE000_0000_0000_0000;
  localparam logic [63:0] F0 = 64'hF000_0000_0000_0000;
  localparam logic [63:0] G0 = 64'h1518_0000_0000_0000;

  // Capture every transferred beat and count error pulses.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.out_vld && bus.out_rdy) begin
        mon_b.sop  = bus.out_seg_sop;
        mon_b.eop  = bus.out_seg_eop;
        mon_b.dval = bus.out_seg_dval;
        mon_b.pnum = bus.out_seg_packet_num;
        mon_b.zero = bus.out_seg_zero_num;
        mon_b.dout = bus.out_seg_dout;
        beats.push_back(mon_b);
      end
      if (bus.err_sop) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_vec(input string tag, input seg_vec_t v);
    beat_t b;
    int s;
    if (v.bi >= beats.size()) begin
      chk($sformatf("%s beat %0d present", tag, v.bi), 64'(beats.size()), 64'(v.bi + 1));
      return;
    end
    b = beats[v.bi];
    s = v.seg;
    chk($sformatf("%s b%0d s%0d sop", tag, v.bi, s),  64'(b.sop[s]),          64'(v.sop));
    chk($sformatf("%s b%0d s%0d eop", tag, v.bi, s),  64'(b.eop[s]),          64'(v.eop));
    chk($sformatf("%s b%0d s%0d dval", tag, v.bi, s), 64'(b.dval[s]),         64'(v.dval));
    chk($sformatf("%s b%0d s%0d pnum", tag, v.bi, s), 64'(b.pnum[4*s +: 4]),  64'(v.pnum));
    chk($sformatf("%s b%0d s%0d zero", tag, v.bi, s), 64'(b.zero[12*s +: 12]), 64'(v.zero));
    chk($sformatf("%s b%0d s%0d dout", tag, v.bi, s), b.dout[64*s +: 64],     v.dout);
  endtask

  task automatic send(input logic sop, input logic eop, input logic [2:0] mod, input logic [63:0] d);
    int t = 0;
    @(negedge clk);
    bus.in_sop  = sop;
    bus.in_eop  = eop;
    bus.in_mod  = mod;
    bus.in_dout = d;
    bus.in_dval = 1'b1;
    while (!bus.in_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("in_rdy wait timeout", 64'(bus.in_rdy), 64'd1);
    @(posedge clk);
  endtask

  task automatic send_pkt(input int words, input logic [2:0] mod, input logic [63:0] base);
    for (int i = 0; i < words; i++)
      send(i == 0, i == words - 1, (i == words - 1) ? mod : 3'd0, base + 64'(i));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_dval = 1'b0;
    bus.in_sop  = 1'b0;
    bus.in_eop  = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int t = 0;
    while (beats.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, 64'(beats.size()), 64'(n));
  endtask

  initial begin
    int n, nerr, k;
    beat_t b;

    // Expected segment contents, derived by hand from the stimulus below.
    t1 = '{'{0,63,1,0,1,1,0,A0},     '{0,56,0,1,1,1,448,A0+7}, '{0,55,1,0,1,2,0,A0+8},
           '{0,48,0,1,1,2,384,A0+15},'{0,30,0,0,1,5,0,A0+33},  '{0,7,1,0,1,8,0,A0+56},
           '{0,0,0,1,1,8,0,A0+63}};
    t2 = '{'{0,63,1,0,1,1,0,B0}, '{0,55,0,1,1,1,447,B0+8}, '{0,54,0,0,0,0,0,64'd0}};
    t3 = '{'{0,0,0,1,1,8,0,C0+63}, '{1,63,1,0,1,1,0,C0+64}, '{1,0,0,1,1,8,0,C0+127},
           '{2,63,1,1,1,1,504,C0+128}, '{2,62,0,0,0,0,0,64'd0}};
    t4 = '{'{0,63,1,0,1,1,0,D0}, '{0,62,0,0,1,1,0,D0+1}, '{0,61,1,0,1,1,0,D0+2},
           '{0,60,0,1,1,1,480,D0+3}, '{0,59,1,1,1,2,472,D0+5}, '{0,58,0,0,0,0,0,64'd0}};
    t5 = '{'{0,63,1,1,1,1,509,F0+100}, '{0,62,0,0,0,0,0,64'd0}};
    t6 = '{'{2,2,0,1,1,1,18,G0+189}, '{2,1,1,0,1,2,0,G0+190},
           '{5,4,0,1,1,1,34,G0+379}, '{5,3,0,0,0,0,0,64'd0}};

    bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_dval = 1'b0;
    bus.in_mod = 3'd0; bus.in_dout = 64'd0; bus.out_rdy = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_vld", 64'(bus.out_vld), 64'd0);
    chk("reset in_rdy",  64'(bus.in_rdy),  64'd1);
    chk("reset err_sop", 64'(bus.err_sop), 64'd0);
    chk("reset dval",    64'(bus.out_seg_dval), 64'd0);
    chk("reset dout",    64'(|bus.out_seg_dout), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Eight back-to-back 8-word packets fill exactly one beat.
    beats.delete();
    for (int p = 0; p < 8; p++) send_pkt(8, 3'd0, A0 + 64'(8 * p));
    #1;
    chk("t1 out_vld latency", 64'(bus.out_vld), 64'd1);
    idle();
    wait_beats("t1 beat count", 1, 10);
    if (beats.size() > 0) begin
      b = beats[0];
      chk("t1 sop mask",  b.sop,  64'h8080_8080_8080_8080);
      chk("t1 eop mask",  b.eop,  64'h0101_0101_0101_0101);
      chk("t1 dval mask", b.dval, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    foreach (t1[i]) check_vec("t1", t1[i]);

    // 65-byte packet flushed after 16 idle cycles.
    beats.delete();
    send_pkt(9, 3'd1, B0);
    idle();
    n = 0;
    while (!bus.out_vld && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t2 flush delay", 64'(n), 64'd16);
    wait_beats("t2 beat count", 1, 5);
    repeat (20) @(posedge clk);
    #1;
    chk("t2 single pulse", 64'(beats.size()), 64'd1);
    if (beats.size() > 0) begin
      b = beats[0];
      chk("t2 dval mask",  b.dval, 64'hFF80_0000_0000_0000);
      chk("t2 eop mask",   b.eop,  64'h0080_0000_0000_0000);
      chk("t2 low dout",   64'(|b.dout[55*64-1:0]), 64'd0);
      chk("t2 low zero",   64'(|b.zero[55*12-1:0]), 64'd0);
      chk("t2 low pnum",   64'(|b.pnum[55*4-1:0]),  64'd0);
    end
    foreach (t2[i]) check_vec("t2", t2[i]);

    // Backpressure: two beats arrive with out_rdy low.
    beats.delete();
    @(negedge clk);
    bus.out_rdy = 1'b0;
    for (int p = 0; p < 16; p++) send_pkt(8, 3'd0, C0 + 64'(8 * p));
    #1;
    chk("t3 in_rdy drops", 64'(bus.in_rdy),  64'd0);
    chk("t3 held vld",     64'(bus.out_vld), 64'd1);
    chk("t3 held seg63",   bus.out_seg_dout[63*64 +: 64], C0);
    chk("t3 held seg0",    bus.out_seg_dout[63:0], C0 + 64'd63);
    chk("t3 no transfer",  64'(beats.size()), 64'd0);
    idle();
    @(negedge clk);
    bus.out_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("t3 in_rdy back",  64'(bus.in_rdy),  64'd1);
    chk("t3 vld after",    64'(bus.out_vld), 64'd1);
    chk("t3 beat2 seg63",  bus.out_seg_dout[63*64 +: 64], C0 + 64'd64);
    chk("t3 one transfer", 64'(beats.size()), 64'd1);
    @(negedge clk);
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3 still one",    64'(beats.size()), 64'd1);
    @(negedge clk);
    bus.out_rdy = 1'b1;
    send(1'b1, 1'b1, 3'd0, C0 + 64'd128);
    idle();
    wait_beats("t3 beat count", 3, 40);
    foreach (t3[i]) check_vec("t3", t3[i]);

    // Protocol errors: sop inside a packet, non-sop word outside a packet.
    beats.delete();
    n = err_cnt;
    send(1'b1, 1'b0, 3'd0, D0);
    send(1'b0, 1'b0, 3'd0, D0 + 64'd1);
    send(1'b1, 1'b0, 3'd0, D0 + 64'd2);
    send(1'b0, 1'b1, 3'd0, D0 + 64'd3);
    send(1'b0, 1'b0, 3'd0, D0 + 64'd4);
    send(1'b1, 1'b1, 3'd0, D0 + 64'd5);
    idle();
    wait_beats("t4 beat count", 1, 40);
    chk("t4 err pulses", 64'(err_cnt - n), 64'd2);
    foreach (t4[i]) check_vec("t4", t4[i]);

    // Reset with a held beat and a partial beat in flight.
    beats.delete();
    @(negedge clk);
    bus.out_rdy = 1'b0;
    for (int p = 0; p < 8; p++) send_pkt(8, 3'd0, E0 + 64'(8 * p));
    send(1'b1, 1'b0, 3'd0, F0);
    for (int i = 1; i < 20; i++) send(1'b0, 1'b0, 3'd0, F0 + 64'(i));
    idle();
    chk("t5 vld before rst", 64'(bus.out_vld), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5 rst out_vld", 64'(bus.out_vld), 64'd0);
    chk("t5 rst in_rdy",  64'(bus.in_rdy),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_rdy = 1'b1;
    send(1'b1, 1'b1, 3'd3, F0 + 64'd100);
    idle();
    wait_beats("t5 beat count", 1, 40);
    if (beats.size() > 0) chk("t5 dval mask", beats[0].dval, 64'h8000_0000_0000_0000);
    foreach (t5[i]) check_vec("t5", t5[i]);

    // Two 1518-byte packets streamed continuously.
    beats.delete();
    ref_q.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 190; i++) begin
        ref_q.push_back(G0 + 64'(p * 190 + i));
        send(i == 0, i == 189, (i == 189) ? 3'd6 : 3'd0, G0 + 64'(p * 190 + i));
      end
    idle();
    wait_beats("t6 beat count", 6, 60);
    nerr = 0;
    k = 0;
    foreach (beats[j])
      for (int s = SN - 1; s >= 0; s--)
        if (beats[j].dval[s]) begin
          if (k >= ref_q.size() || beats[j].dout[64*s +: 64] !== ref_q[k]) nerr++;
          k++;
        end
    chk("t6 word count",     64'(k),    64'd380);
    chk("t6 data mismatches", 64'(nerr), 64'd0);
    foreach (t6[i]) check_vec("t6", t6[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
